// File: rtl/boot_pkg.sv
// rtl/boot_pkg.sv - shared states and frame constants for the UART boot loader.
package boot_pkg;

    localparam logic [7:0] SYNC_BYTE      = 8'hA5;
    localparam int         BYTES_PER_WORD = 4;
    localparam int         COUNT_W        = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CNT_LO,
        ST_CNT_HI,
        ST_DATA,
        ST_CSUM,
        ST_DONE,
        ST_ERR
    } boot_state_e;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_BITS,
        RX_STOP
    } rx_state_e;

endpackage

// File: rtl/uart_rx_core.sv
// rtl/uart_rx_core.sv - 8N1 UART receiver: synchronizer, mid-bit sampler, shift register.
module uart_rx_core #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);
    import boot_pkg::*;

    localparam int            CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

    logic          rx_meta_q, rx_sync_q, rx_prev_q;
    rx_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          valid_q, valid_d;
    logic          ferr_q, ferr_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
            state_q   <= RX_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            RX_IDLE: begin
                if (rx_prev_q && !rx_sync_q) begin
                    state_d = RX_START;
                    cnt_d   = '0;
                end
            end
            RX_START: begin
                // A line that is high again at mid start bit was only a glitch.
                if (cnt_q == HALF) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rx_sync_q ? RX_IDLE : RX_BITS;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RX_BITS: begin
                if (cnt_q == FULL) begin
                    cnt_d   = '0;
                    shift_d = {rx_sync_q, shift_q[7:1]};
                    if (bit_q == 3'd7) state_d = RX_STOP;
                    else               bit_d   = bit_q + 3'd1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RX_STOP: begin
                if (cnt_q == FULL) begin
                    cnt_d   = '0;
                    state_d = RX_IDLE;
                    valid_d = rx_sync_q;
                    ferr_d  = !rx_sync_q;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    assign byte_valid = valid_q;
    assign byte_data  = shift_q;
    assign frame_err  = ferr_q;

endmodule

// File: rtl/uart_boot_loader.sv
// rtl/uart_boot_loader.sv - receives a framed image over UART, writes it to instruction
// RAM and releases the CPU from reset once the checksum matches.
module uart_boot_loader #(
    parameter int CLKS_PER_BIT = 868,
    parameter int ADDR_W       = 8,
    parameter int TIMEOUT_CYC  = 1000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              uart_rx,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_rst,
    output logic              boot_done,
    output logic              boot_err
);
    import boot_pkg::*;

    localparam int AW1   = ADDR_W + 1;
    localparam int TW    = $clog2(TIMEOUT_CYC + 1);
    localparam int DEPTH = 2 ** ADDR_W;

    logic               byte_valid, frame_err;
    logic [7:0]         byte_data;

    boot_state_e        state_q, state_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic [AW1-1:0]     addr_q, addr_d;
    logic [1:0]         byte_idx_q, byte_idx_d;
    logic [23:0]        word_q, word_d;
    logic               we_q, we_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [7:0]         csum_q, csum_d;
    logic [TW-1:0]      to_cnt_q, to_cnt_d;
    logic [COUNT_W-1:0] n_words;
    logic               counting, timeout_fire;

    uart_rx_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk        (clk),
        .rst        (rst),
        .rx         (uart_rx),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .frame_err  (frame_err)
    );

    assign counting     = (state_q == ST_CNT_LO) || (state_q == ST_CNT_HI) ||
                          (state_q == ST_DATA)   || (state_q == ST_CSUM);
    // Counter holds "cycles since the last byte_valid", so firing at TIMEOUT_CYC-1
    // puts boot_err exactly TIMEOUT_CYC cycles after that byte_valid.
    assign timeout_fire = counting && !byte_valid && (to_cnt_q == TW'(TIMEOUT_CYC - 1));
    assign n_words      = {byte_data, count_q[7:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            addr_q     <= '0;
            byte_idx_q <= '0;
            word_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            csum_q     <= '0;
            to_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            addr_q     <= addr_d;
            byte_idx_q <= byte_idx_d;
            word_q     <= word_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            csum_q     <= csum_d;
            to_cnt_q   <= to_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        addr_d     = addr_q;
        byte_idx_d = byte_idx_q;
        word_d     = word_q;
        we_d       = 1'b0;
        wdata_d    = wdata_q;
        csum_d     = csum_q;
        to_cnt_d   = to_cnt_q;

        if (we_q) addr_d = addr_q + AW1'(1);

        if (byte_valid)                         to_cnt_d = TW'(1);
        else if (!counting)                     to_cnt_d = '0;
        else if (to_cnt_q != TW'(TIMEOUT_CYC))  to_cnt_d = to_cnt_q + TW'(1);

        case (state_q)
            ST_IDLE, ST_ERR: begin
                if (byte_valid && byte_data == SYNC_BYTE) begin
                    state_d = ST_CNT_LO;
                    csum_d  = '0;
                end
            end
            ST_CNT_LO: begin
                if (byte_valid) begin
                    count_d[7:0] = byte_data;
                    state_d      = ST_CNT_HI;
                end
            end
            ST_CNT_HI: begin
                if (byte_valid) begin
                    count_d    = n_words;
                    addr_d     = '0;
                    byte_idx_d = '0;
                    if (n_words == '0 || 32'(n_words) > 32'(DEPTH)) state_d = ST_ERR;
                    else                                           state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (byte_valid) begin
                    word_d     = {byte_data, word_q[23:8]};
                    csum_d     = csum_q + byte_data;
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'(BYTES_PER_WORD - 1)) begin
                        we_d    = 1'b1;
                        wdata_d = {byte_data, word_q};
                        if (32'(addr_q) + 32'd1 == 32'(count_q)) state_d = ST_CSUM;
                    end
                end
            end
            ST_CSUM: begin
                if (byte_valid) state_d = (byte_data == csum_q) ? ST_DONE : ST_ERR;
            end
            default: ;
        endcase

        if (counting && (frame_err || timeout_fire)) state_d = ST_ERR;
    end

    assign imem_we    = we_q;
    assign imem_addr  = addr_q[ADDR_W-1:0];
    assign imem_wdata = wdata_q;
    assign cpu_rst    = (state_q != ST_DONE);
    assign boot_done  = (state_q == ST_DONE);
    assign boot_err   = (state_q == ST_ERR);

endmodule

// File: tb/tb_uart_boot_loader.sv
// tb/tb_uart_boot_loader.sv - scoreboard bench: serial frames in, expected RAM writes
// queued by a frame-level model and matched by an independent write monitor.
module tb_uart_boot_loader;

    localparam int CPB = 16;
    localparam int AW  = 5;
    localparam int TO  = 1000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          uart_rx = 1'b1;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          cpu_rst, boot_done, boot_err;

    int            checks = 0;
    int            errors = 0;
    logic [63:0]   exp_q[$];
    logic [63:0]   mon_e;
    logic [31:0]   img [0:31];
    int            bv_age = 0;

    always #5 clk = ~clk;

    uart_boot_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(AW), .TIMEOUT_CYC(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .uart_rx    (uart_rx),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_rst    (cpu_rst),
        .boot_done  (boot_done),
        .boot_err   (boot_err)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Write monitor: every strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write actual=%0d:%h required=none", imem_addr, imem_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                chk("imem_write", {32'(imem_addr), imem_wdata}, mon_e);
            end
        end
    end

    // Cycles elapsed since the receiver's last byte_valid (time reference only).
    always @(posedge clk) begin
        if (dut.byte_valid === 1'b1) bv_age <= 1;
        else                         bv_age <= bv_age + 1;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    task automatic send_byte(input logic [7:0] b, input bit good_stop);
        @(posedge clk);
        uart_rx = 1'b0;
        repeat (CPB) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(posedge clk);
        end
        uart_rx = good_stop;
        repeat (CPB) @(posedge clk);
        if (!good_stop) begin
            uart_rx = 1'b1;
            repeat (CPB) @(posedge clk);
        end
        uart_rx = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_cpu_rst"},    cpu_rst,    1);
        chk({tag, "_boot_done"},  boot_done,  0);
        chk({tag, "_boot_err"},   boot_err,   0);
        chk({tag, "_imem_we"},    imem_we,    0);
        chk({tag, "_imem_addr"},  imem_addr,  0);
        chk({tag, "_imem_wdata"}, imem_wdata, 0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        rst = 1'b0;
    endtask

    task automatic fill_random(input int n);
        for (int w = 0; w < n; w++) img[w] = $urandom;
    endtask

    // Frame model: N in 1..32 is accepted; every word whose 4 bytes arrive intact is
    // written at its index; success needs a valid N, no framing error and a good sum.
    task automatic run_frame(input int n_field, input bit bad_csum, input int ferr_idx,
                             input string tag);
        logic [7:0] csum;
        logic [7:0] b;
        bit         n_ok;
        bit         expect_ok;
        csum      = 8'h00;
        n_ok      = (n_field >= 1) && (n_field <= 32);
        expect_ok = n_ok && !bad_csum && (ferr_idx < 0);
        send_byte(8'hA5, 1'b1);
        send_byte(n_field[7:0], 1'b1);
        send_byte(n_field[15:8], 1'b1);
        if (n_ok) begin
            for (int w = 0; w < n_field; w++)
                if (ferr_idx < 0 || (w * 4 + 3) < ferr_idx)
                    exp_q.push_back({32'(w), img[w]});
            for (int i = 0; i < n_field * 4; i++) begin
                b    = img[i / 4][8 * (i % 4) +: 8];
                csum = csum + b;
                send_byte(b, i != ferr_idx);
                if (i == ferr_idx) break;
            end
            if (ferr_idx < 0) send_byte(bad_csum ? csum + 8'd1 : csum, 1'b1);
        end
        repeat (4) @(negedge clk);
        chk({tag, "_boot_done"}, boot_done, expect_ok);
        chk({tag, "_boot_err"},  boot_err,  !expect_ok);
        chk({tag, "_cpu_rst"},   cpu_rst,   !expect_ok);
    endtask

    initial begin
        int n;
        int k;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        img[0] = 32'h0AA00093;
        img[1] = 32'h100000B7;
        run_frame(2, 1'b0, -1, "good_load");
        do_reset();

        run_frame(2, 1'b1, -1, "bad_csum");
        n = $urandom_range(1, 4);
        fill_random(n);
        run_frame(n, 1'b0, -1, "retry_after_csum");
        do_reset();

        run_frame(0, 1'b0, -1, "count_zero");
        run_frame(33, 1'b0, -1, "count_33");
        do_reset();

        send_byte(8'h55, 1'b1);
        send_byte(8'hFF, 1'b1);
        send_byte(8'h00, 1'b1);
        @(posedge clk);
        uart_rx = 1'b0;
        repeat (5) @(posedge clk);
        uart_rx = 1'b1;
        repeat (40) @(negedge clk);
        chk("noise_no_err", boot_err, 0);
        n = $urandom_range(1, 4);
        fill_random(n);
        run_frame(n, 1'b0, -1, "after_noise");
        do_reset();

        fill_random(3);
        run_frame(3, 1'b0, 2, "frame_err");
        n = $urandom_range(1, 4);
        fill_random(n);
        run_frame(n, 1'b0, -1, "retry_after_ferr");
        do_reset();

        fill_random(32);
        run_frame(32, 1'b0, -1, "full_depth");
        do_reset();

        send_byte(8'hA5, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h93, 1'b1);
        send_byte(8'h00, 1'b1);
        k = 0;
        while (boot_err !== 1'b1 && k < 3 * TO) begin
            @(negedge clk);
            k++;
        end
        chk("timeout_seen", boot_err, 1);
        chk("timeout_latency", bv_age, TO);
        chk("timeout_cpu_rst", cpu_rst, 1);
        do_reset();

        fill_random(4);
        exp_q.push_back({32'd0, img[0]});
        send_byte(8'hA5, 1'b1);
        send_byte(8'h04, 1'b1);
        send_byte(8'h00, 1'b1);
        for (int i = 0; i < 5; i++) send_byte(img[i / 4][8 * (i % 4) +: 8], 1'b1);
        @(posedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("mid_rst");
        rst = 1'b0;
        n = $urandom_range(1, 4);
        fill_random(n);
        run_frame(n, 1'b0, -1, "after_rst");

        repeat (4) @(negedge clk);
        chk("pending_writes", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
